// File: rtl/f2c_dma_sched_pkg.sv
// rtl/f2c_dma_sched_pkg.sv - shared types and helpers for the f2c DMA burst scheduler
package f2c_dma_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sched_state_e;

  typedef logic [63:0] uint64_t;
  typedef logic [31:0] burst_count_t;

  // Width of a source index; a single source still gets one bit.
  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/f2c_dma_sched_rr_arbiter.sv
// rtl/f2c_dma_sched_rr_arbiter.sv - combinational round-robin search starting at ptr
module f2c_dma_sched_rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int          cand;
  logic [N-1:0] hit;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    hit   = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      hit = (req >> cand) & N'(1);
      if (!found && (hit != '0)) begin
        found = 1'b1;
        idx   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/f2c_dma_sched.sv
// rtl/f2c_dma_sched.sv - round-robin burst scheduler sharing the f2c DMA stream between sources
module f2c_dma_sched
  import f2c_dma_sched_pkg::*;
#(
  parameter int  NUM_SRC   = 2,
  parameter int  BURST_LEN = 16,
  localparam int SRC_W     = src_width(NUM_SRC)
) (
  input  logic                  pcieClk_in,
  input  logic                  pcieRstN_in,
  input  logic [NUM_SRC-1:0]    enMask_in,
  input  logic [NUM_SRC*64-1:0] srcData_in,
  input  logic [NUM_SRC-1:0]    srcValid_in,
  output logic [NUM_SRC-1:0]    srcReady_out,
  output logic                  srcReset_out,
  output logic [63:0]           f2cData_out,
  output logic                  f2cValid_out,
  input  logic                  f2cReady_in,
  input  logic                  f2cReset_in,
  output logic [SRC_W-1:0]      grant_out,
  output logic                  busy_out,
  output logic [31:0]           burstCount_out
);

  localparam int                BEAT_W    = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [SRC_W-1:0]  LAST_SRC  = SRC_W'(NUM_SRC - 1);

  sched_state_e       state, state_next;
  logic [SRC_W-1:0]   grant, rr_ptr, arb_idx;
  logic [BEAT_W-1:0]  beat_cnt;
  burst_count_t       burst_count;
  logic               src_reset;
  logic               arb_found;
  logic               beat_done, burst_end;
  logic               sel_valid;
  uint64_t            sel_data;
  logic [NUM_SRC-1:0] req;

  assign req = enMask_in & srcValid_in;

  f2c_dma_sched_rr_arbiter #(
    .N (NUM_SRC),
    .W (SRC_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .found (arb_found),
    .idx   (arb_idx)
  );

  // Compare-based mux so an out-of-range grant can never select a missing lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == SRC_W'(i)) begin
        sel_valid = srcValid_in[i];
        sel_data  = srcData_in[i*64 +: 64];
      end
    end
  end

  always_comb begin
    state_next   = state;
    f2cValid_out = 1'b0;
    f2cData_out  = '0;
    srcReady_out = '0;
    beat_done    = 1'b0;
    burst_end    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) state_next = STREAM;
      end
      STREAM: begin
        f2cData_out = sel_data;
        if (!f2cReset_in) begin
          f2cValid_out = sel_valid;
          for (int i = 0; i < NUM_SRC; i++) begin
            srcReady_out[i] = f2cReady_in && (grant == SRC_W'(i));
          end
          beat_done = sel_valid && f2cReady_in;
          burst_end = beat_done && (beat_cnt == LAST_BEAT);
          if (burst_end) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (f2cReset_in) state_next = IDLE;
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) state <= IDLE;
    else              state <= state_next;
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      grant       <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      burst_count <= '0;
      src_reset   <= 1'b0;
    end else begin
      src_reset <= f2cReset_in;
      if (f2cReset_in) begin
        grant       <= '0;
        rr_ptr      <= '0;
        beat_cnt    <= '0;
        burst_count <= '0;
      end else if (state == IDLE) begin
        if (arb_found) begin
          grant    <= arb_idx;
          beat_cnt <= '0;
        end
      end else if (beat_done) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
        if (burst_end) begin
          rr_ptr      <= (grant == LAST_SRC) ? '0 : grant + SRC_W'(1);
          burst_count <= burst_count + 32'd1;
        end
      end
    end
  end

  assign grant_out      = grant;
  assign busy_out       = (state == STREAM);
  assign burstCount_out = burst_count;
  assign srcReset_out   = src_reset;

endmodule

// File: tb/tb_f2c_dma_sched.sv
// tb/tb_f2c_dma_sched.sv - randomized bench for f2c_dma_sched against a burst-level reference model
module tb_f2c_dma_sched;

  localparam int NS     = 3;
  localparam int BL     = 8;
  localparam int SW     = 2;
  localparam int CYCLES = 3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS-1:0]    en_mask;
  logic [NS*64-1:0] src_data;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic             src_reset;
  logic [63:0]      f2c_data;
  logic             f2c_valid;
  logic             f2c_ready;
  logic             f2c_reset;
  logic [SW-1:0]    grant;
  logic             busy;
  logic [31:0]      burst_count;

  int n_tests = 0;
  int n_fail  = 0;

  bit            m_busy;
  logic [SW-1:0] m_grant;
  logic [SW-1:0] m_ptr;
  int            m_beats;
  logic [31:0]   m_bursts;
  bit            m_srst;
  bit            did_async = 0;

  always #5 clk = ~clk;

  f2c_dma_sched #(
    .NUM_SRC   (NS),
    .BURST_LEN (BL)
  ) dut (
    .pcieClk_in     (clk),
    .pcieRstN_in    (rst_n),
    .enMask_in      (en_mask),
    .srcData_in     (src_data),
    .srcValid_in    (src_valid),
    .srcReady_out   (src_ready),
    .srcReset_out   (src_reset),
    .f2cData_out    (f2c_data),
    .f2cValid_out   (f2c_valid),
    .f2cReady_in    (f2c_ready),
    .f2cReset_in    (f2c_reset),
    .grant_out      (grant),
    .busy_out       (busy),
    .burstCount_out (burst_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_grant  = '0;
    m_ptr    = '0;
    m_beats  = 0;
    m_bursts = '0;
    m_srst   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {63'd0, f2c_valid}, 64'd0);
    check({tag, "_ready"}, {61'd0, src_ready}, 64'd0);
    check({tag, "_data"}, f2c_data, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_grant"}, {62'd0, grant}, 64'd0);
    check({tag, "_count"}, {32'd0, burst_count}, 64'd0);
    check({tag, "_srst"}, {63'd0, src_reset}, 64'd0);
  endtask

  task automatic drive(input int it);
    for (int i = 0; i < NS; i++) src_data[i*64 +: 64] = {$urandom, $urandom};
    if (it < 300) begin
      en_mask   = '1;
      src_valid = '1;
      f2c_ready = 1'b1;
      f2c_reset = 1'b0;
    end else begin
      en_mask = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '1;
      for (int i = 0; i < NS; i++) src_valid[i] = ($urandom_range(0, 9) < 8);
      f2c_ready = ($urandom_range(0, 2) != 0);
      f2c_reset = (it >= 1500) && ($urandom_range(0, 39) == 0);
    end
  endtask

  // Compare the cycle's outputs, then advance the model by what the next edge should do.
  task automatic step();
    bit            exp_valid;
    logic [NS-1:0] exp_ready;
    bit            flush;
    logic [SW-1:0] c;
    @(negedge clk);
    exp_valid = m_busy && !f2c_reset && src_valid[m_grant];
    exp_ready = '0;
    if (m_busy && !f2c_reset && f2c_ready) exp_ready[m_grant] = 1'b1;
    check("valid", {63'd0, f2c_valid}, {63'd0, exp_valid});
    check("ready", {61'd0, src_ready}, {61'd0, exp_ready});
    check("busy", {63'd0, busy}, {63'd0, m_busy});
    check("grant", {62'd0, grant}, {62'd0, m_grant});
    check("count", {32'd0, burst_count}, {32'd0, m_bursts});
    check("srst", {63'd0, src_reset}, {63'd0, m_srst});
    if (m_busy) check("data", f2c_data, src_data[int'(m_grant)*64 +: 64]);

    flush = f2c_reset;
    if (flush) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 0; k < NS; k++) begin
        c = SW'((int'(m_ptr) + k) % NS);
        if (!m_busy && en_mask[c] && src_valid[c]) begin
          m_busy  = 1'b1;
          m_grant = c;
          m_beats = 0;
        end
      end
    end else if (exp_valid && f2c_ready) begin
      m_beats++;
      if (m_beats == BL) begin
        m_busy   = 1'b0;
        m_ptr    = SW'((int'(m_grant) + 1) % NS);
        m_bursts = m_bursts + 32'd1;
      end
    end
    m_srst = flush;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0);
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int it = 0; it < CYCLES; it++) begin
      step();
      @(posedge clk);
      #1;
      drive(it + 1);
      if (!did_async && it >= 200 && m_busy) begin
        did_async = 1;
        async_reset();
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/f2c_dma_sched.md
Name: f2c_dma_sched

Overview:
- Round-robin burst scheduler for the FPGA->CPU DMA stream port of tlp_xcvr (f2cData/f2cValid/f2cReady/f2cReset).
- Shares that single stream between NUM_SRC 64-bit valid/ready data sources, for example the RNG and the C2F consumer checksum.
- Grants whole bursts of BURST_LEN beats, one source at a time.
- Forwards the f2c reset from tlp_xcvr to all sources and exposes grant/status for the register array.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- BURST_LEN, 16, 64-bit beats per granted burst (power of two, 2..256).

Ports:
- pcieClk_in  in  1  125MHz PCIe clock; the only clock.
- pcieRstN_in  in  1  asynchronous active-low reset.
- enMask_in  in  NUM_SRC  per-source enable, from the register array.
- srcData_in  in  NUM_SRC x 64  source data.
- srcValid_in  in  NUM_SRC  source valid.
- srcReady_out  out  NUM_SRC  source ready.
- srcReset_out  out  1  reset to all sources, registered copy of f2cReset_in.
- f2cData_out  out  64  to tlp_xcvr f2cData_in.
- f2cValid_out  out  1  to tlp_xcvr f2cValid_in.
- f2cReady_in  in  1  from tlp_xcvr f2cReady_out.
- f2cReset_in  in  1  synchronous flush, from tlp_xcvr f2cReset_out.
- grant_out  out  SRC_W  index of the current or last granted source; SRC_W = max(1, clog2(NUM_SRC)).
- busy_out  out  1  1 while in STREAM.
- burstCount_out  out  32  completed bursts since reset or flush; wraps mod 2^32.

Behaviour:
- Reset (pcieRstN_in=0, asynchronous):
  - state=IDLE, grant=0, rrPtr=0, beatCnt=0, burstCount=0, srcReset_out=0.
  - All outputs are 0 while reset is asserted: f2cValid_out=0, srcReady_out=0, f2cData_out=0.
- States: IDLE, STREAM.
- IDLE:
  - f2cValid_out=0, srcReady_out=0.
  - Each cycle, request vector req = enMask_in & srcValid_in.
  - Search order is rrPtr, rrPtr+1, ..., wrapping modulo NUM_SRC.
  - First hit i: grant<=i, beatCnt<=0, state<=STREAM at the next edge.
  - No hit: stay in IDLE.
- STREAM datapath (combinational mux, zero latency):
  - f2cData_out = srcData_in[grant].
  - f2cValid_out = srcValid_in[grant].
  - srcReady_out[grant] = f2cReady_in; all other ready bits are 0.
- STREAM beat handling:
  - A beat completes on f2cValid_out & f2cReady_in.
  - Each completed beat: beatCnt<=beatCnt+1.
  - If the source drops valid mid-burst, the burst stalls. The grant is held, with no timeout.
- End of burst, i.e. a beat completes with beatCnt==BURST_LEN-1:
  - state<=IDLE, rrPtr<=(grant+1) mod NUM_SRC, burstCount<=burstCount+1.
  - This gives at least one idle (bubble) cycle between bursts, including for back-to-back requests from the same source.
- enMask_in changes:
  - Sampled only in IDLE.
  - Deasserting the bit of the granted source mid-burst does not abort it; the burst completes.
- Fairness: with every source continuously requesting, grants rotate 0,1,...,NUM_SRC-1,0,...
- Flush, f2cReset_in=1 sampled in any state:
  - Next edge: state=IDLE, rrPtr=0, grant=0, beatCnt=0, burstCount=0, srcReset_out=1.
  - While f2cReset_in=1: f2cValid_out=0 and srcReady_out=0 combinationally. No beat can complete in the flush cycle.
  - A partially sent burst is abandoned.
- srcReset_out: one-cycle-registered copy of f2cReset_in.
- Status outputs:
  - grant_out reflects the grant register; it holds its last value in IDLE.
  - busy_out = (state==STREAM).
- No X on any output after reset. srcData_in with index >= NUM_SRC is never selected.

Decomposition:
- Add to tlp_xcvr_pkg (or a new f2c_sched_pkg):
  - typedef SchedState {IDLE, STREAM}.
  - typedef SrcIndex, SRC_W bits.
  - BurstCount, 32-bit.
- Reuse the existing uint64 typedef for data.
- One sub-module: rr_arbiter (request vector + rrPtr -> found flag + index). It is combinational and reusable for other shared resources.

Test Plan:
- Only src0 enabled, valid always high, f2cReady_in=1 -> 16 beats from src0, one idle cycle, repeat; burstCount_out increments by 1 per 17 cycles.
- Both enabled and valid, data tagged 0xA..., 0xB... -> grant_out sequence 0,1,0,1; each burst is exactly 16 beats of one tag, never interleaved.
- f2cReady_in toggling 1,0 pattern -> each burst still 16 beats over 32 cycles; unselected srcReady_out=0 throughout.
- src1 drops valid for 5 cycles at beat 7 -> grant stays 1 and f2cValid_out=0 for 5 cycles; burst ends at 16 beats; src0 waits.
- f2cReset_in pulse at beat 9 -> next cycle srcReset_out=1, busy_out=0, burstCount_out=0; after release, src0 is granted first.
- pcieRstN_in asserted asynchronously mid-burst -> outputs 0 before the next edge; after release, IDLE with grant_out=0.
